// File: rtl/fetch_unit.sv
// Instruction fetch unit: a registered pc drives the instruction cache, a two-state
// SETTLE/WAIT sequencer captures returned words, and a small FIFO feeds decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] icache_address,
  input  logic [31:0] icache_instruction,
  input  logic        icache_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [31:0]      PC_RST   = {RESET_PC[31:2], 2'b00};

  typedef enum logic {
    SETTLE = 1'b0,
    WAIT   = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_pc;
  logic [31:0]       w_pc_nxt;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_q_instr [DEPTH];
  logic [31:0]       r_q_pc    [DEPTH];
  logic              w_unused_bits;

  // Low address bits of a redirect target are architecturally meaningless.
  assign w_unused_bits = ^redirect_pc[1:0];

  assign w_pop = out_valid && out_ready;

  // Fullness is judged on the count held this cycle, so a pop never frees a slot early.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    if (redirect_valid) begin
      w_state_nxt = SETTLE;
      w_pc_nxt    = {redirect_pc[31:2], 2'b00};
    end else begin
      case (r_state)
        SETTLE: w_state_nxt = WAIT;
        WAIT: begin
          if (icache_valid && (r_count < FULL_CNT)) begin
            w_push      = 1'b1;
            w_pc_nxt    = r_pc + 32'd4;
            w_state_nxt = SETTLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SETTLE;
      r_pc    <= PC_RST;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Queue bookkeeping; a redirect flushes even when a handshake completes in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= icache_instruction;
      r_q_pc[r_wr_ptr]    <= r_pc;
    end
  end

  assign icache_address = r_pc;
  assign out_valid      = (r_count != '0);
  assign out_instr      = r_q_instr[r_rd_ptr];
  assign out_pc         = r_q_pc[r_rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-programmable cache model, directed scenarios and a
// randomized run scored against an in-order stream model of the fetched addresses.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] icache_address;
  logic [31:0] icache_instruction = 32'h0;
  logic        icache_valid = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int vectors = 0;
  int errors  = 0;

  int          cache_delay = 0;
  logic [31:0] prev_addr = 32'hFFFF_FFFF;
  int          stable = 0;
  int          stable_nxt;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .icache_address(icache_address),
    .icache_instruction(icache_instruction),
    .icache_valid(icache_valid),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a >> 2;
  endfunction

  // Cache: registers the word for the presented address; valid once the address
  // has been held for cache_delay further cycles.
  assign stable_nxt = (icache_address == prev_addr) ? stable + 1 : 0;
  always @(posedge clk) begin
    prev_addr          <= icache_address;
    stable             <= (stable_nxt > 1000) ? 1000 : stable_nxt;
    icache_instruction <= rom(icache_address);
    icache_valid       <= (stable_nxt >= cache_delay);
  end

  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc, input logic rs,
                      output logic ov, output logic [31:0] opc, output logic [31:0] oins,
                      output logic [31:0] ia);
    @(negedge clk);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    rst            = rs;
    #1;
    ov   = out_valid;
    opc  = out_pc;
    oins = out_instr;
    ia   = icache_address;
    @(posedge clk);
  endtask

  task automatic do_reset();
    logic ov; logic [31:0] opc, oins, ia;
    step(1'b0, 1'b0, 32'h0, 1'b1, ov, opc, oins, ia);
    step(1'b0, 1'b0, 32'h0, 1'b1, ov, opc, oins, ia);
  endtask

  task automatic test_reset();
    logic ov; logic [31:0] opc, oins, ia;
    cache_delay = 0;
    step(1'b0, 1'b0, 32'h0, 1'b1, ov, opc, oins, ia);
    step(1'b0, 1'b0, 32'h0, 1'b1, ov, opc, oins, ia);
    step(1'b1, 1'b1, 32'h0000_0500, 1'b1, ov, opc, oins, ia);
    vectors++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", ov); end
    vectors++; if (ia !== RESET_PC) begin errors++; $display("FAIL reset_addr got=%h want=%h", ia, RESET_PC); end
    step(1'b1, 1'b0, 32'h0, 1'b0, ov, opc, oins, ia);
    vectors++; if (ia !== RESET_PC || ov !== 1'b0) begin
      errors++; $display("FAIL reset_over_redirect addr=%h valid=%b want addr=%h valid=0", ia, ov, RESET_PC);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, ov, opc, oins, ia);
    vectors++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_early_capture got=%b want=0", ov); end
    step(1'b1, 1'b0, 32'h0, 1'b0, ov, opc, oins, ia);
    vectors++; if (ov !== 1'b1 || opc !== RESET_PC) begin
      errors++; $display("FAIL reset_first_fetch valid=%b pc=%h want valid=1 pc=%h", ov, opc, RESET_PC);
    end
  endtask

  task automatic test_stream(input int delay, input int period, input int want_cnt);
    logic ov; logic [31:0] opc, oins, ia;
    int k, last;
    cache_delay = delay;
    do_reset();
    k = 0; last = 0;
    for (int c = 0; c < 60; c++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, ov, opc, oins, ia);
      if (ov) begin
        vectors++; if (opc !== 32'(k * 4) || oins !== 32'(k)) begin
          errors++; $display("FAIL stream_d%0d_data pc=%h instr=%h want pc=%h instr=%h", delay, opc, oins, k * 4, k);
        end
        if (k > 0) begin
          vectors++; if (c - last != period) begin
            errors++; $display("FAIL stream_d%0d_rate gap=%0d want=%0d", delay, c - last, period);
          end
        end
        last = c; k++;
      end
    end
    vectors++; if (k != want_cnt) begin errors++; $display("FAIL stream_d%0d_count got=%0d want=%0d", delay, k, want_cnt); end
  endtask

  task automatic test_full();
    logic ov; logic [31:0] opc, oins, ia, exp_pc;
    cache_delay = 0;
    do_reset();
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 32'h0, 1'b0, ov, opc, oins, ia);
    vectors++; if (ia !== 32'h10 || ov !== 1'b1) begin
      errors++; $display("FAIL full_hold addr=%h valid=%b want addr=00000010 valid=1", ia, ov);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, ov, opc, oins, ia);
    vectors++; if (opc !== 32'h0) begin errors++; $display("FAIL full_head pc=%h want=00000000", opc); end
    step(1'b0, 1'b0, 32'h0, 1'b0, ov, opc, oins, ia);
    vectors++; if (ia !== 32'h10) begin errors++; $display("FAIL full_pop_no_capture addr=%h want=00000010", ia); end
    step(1'b0, 1'b0, 32'h0, 1'b0, ov, opc, oins, ia);
    vectors++; if (ia !== 32'h14) begin errors++; $display("FAIL full_resume addr=%h want=00000014", ia); end
    exp_pc = 32'h4;
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, ov, opc, oins, ia);
      if (ov) begin
        vectors++; if (opc !== exp_pc || oins !== rom(exp_pc)) begin
          errors++; $display("FAIL full_drain pc=%h instr=%h want pc=%h instr=%h", opc, oins, exp_pc, rom(exp_pc));
        end
        exp_pc += 4;
      end
    end
    vectors++; if (exp_pc < 32'h1C) begin errors++; $display("FAIL full_drain_count next=%h want>=0000001c", exp_pc); end
  endtask

  task automatic wait_addr(input logic [31:0] target, input string name);
    logic ov; logic [31:0] opc, oins, ia;
    int n;
    n = 0; ia = 32'hDEAD_BEEF;
    while (ia !== target && n < 30) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, ov, opc, oins, ia);
      n++;
    end
    vectors++; if (ia !== target) begin errors++; $display("FAIL %s_timeout addr=%h want=%h", name, ia, target); end
  endtask

  task automatic expect_first(input logic [31:0] pc, input string name);
    logic ov; logic [31:0] opc, oins, ia;
    int n;
    n = 0; ov = 1'b0;
    while (!ov && n < 20) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, ov, opc, oins, ia);
      n++;
    end
    vectors++; if (ov !== 1'b1 || opc !== pc || oins !== rom(pc)) begin
      errors++; $display("FAIL %s_first valid=%b pc=%h instr=%h want pc=%h instr=%h", name, ov, opc, oins, pc, rom(pc));
    end
  endtask

  task automatic test_redirect();
    logic ov; logic [31:0] opc, oins, ia;
    cache_delay = 0;
    do_reset();
    wait_addr(32'hC, "redirect_fill");
    step(1'b0, 1'b1, 32'h0000_0103, 1'b0, ov, opc, oins, ia);
    vectors++; if (ov !== 1'b1) begin errors++; $display("FAIL redirect_prefill valid=%b want=1", ov); end
    step(1'b1, 1'b0, 32'h0, 1'b0, ov, opc, oins, ia);
    vectors++; if (ov !== 1'b0 || ia !== 32'h100) begin
      errors++; $display("FAIL redirect_flush valid=%b addr=%h want valid=0 addr=00000100", ov, ia);
    end
    expect_first(32'h100, "redirect");
  endtask

  task automatic test_redirect_pop();
    logic ov; logic [31:0] opc, oins, ia;
    cache_delay = 0;
    do_reset();
    wait_addr(32'h8, "rpop_fill");
    step(1'b1, 1'b1, 32'h0000_0200, 1'b0, ov, opc, oins, ia);
    vectors++; if (ov !== 1'b1 || opc !== 32'h0) begin
      errors++; $display("FAIL rpop_head valid=%b pc=%h want valid=1 pc=00000000", ov, opc);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, ov, opc, oins, ia);
    vectors++; if (ov !== 1'b0 || ia !== 32'h200) begin
      errors++; $display("FAIL rpop_flush valid=%b addr=%h want valid=0 addr=00000200", ov, ia);
    end
    expect_first(32'h200, "rpop");
  endtask

  task automatic test_back_to_back();
    logic ov; logic [31:0] opc, oins, ia;
    cache_delay = 1;
    do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, ov, opc, oins, ia);
    step(1'b1, 1'b1, 32'h0000_0300, 1'b0, ov, opc, oins, ia);
    step(1'b1, 1'b1, 32'h0000_0402, 1'b0, ov, opc, oins, ia);
    step(1'b1, 1'b0, 32'h0, 1'b0, ov, opc, oins, ia);
    vectors++; if (ia !== 32'h400 || ov !== 1'b0) begin
      errors++; $display("FAIL b2b_last_wins addr=%h valid=%b want addr=00000400 valid=0", ia, ov);
    end
    expect_first(32'h400, "b2b");
  endtask

  task automatic test_wrap();
    logic ov; logic [31:0] opc, oins, ia;
    int k;
    logic [31:0] want [2];
    want[0] = 32'hFFFF_FFFC; want[1] = 32'h0000_0000;
    cache_delay = 0;
    do_reset();
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, ov, opc, oins, ia);
    k = 0;
    for (int c = 0; c < 20 && k < 2; c++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, ov, opc, oins, ia);
      if (ov) begin
        vectors++; if (opc !== want[k] || oins !== rom(want[k])) begin
          errors++; $display("FAIL wrap_seq%0d pc=%h instr=%h want pc=%h instr=%h", k, opc, oins, want[k], rom(want[k]));
        end
        k++;
      end
    end
    vectors++; if (k != 2) begin errors++; $display("FAIL wrap_count got=%0d want=2", k); end
    for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 32'h0, 1'b0, ov, opc, oins, ia);
    step(1'b0, 1'b0, 32'h0, 1'b1, ov, opc, oins, ia);
    vectors++; if (ov !== 1'b1) begin errors++; $display("FAIL wrap_prereset valid=%b want=1", ov); end
    step(1'b1, 1'b0, 32'h0, 1'b0, ov, opc, oins, ia);
    vectors++; if (ov !== 1'b0 || ia !== RESET_PC) begin
      errors++; $display("FAIL wrap_midreset valid=%b addr=%h want valid=0 addr=%h", ov, ia, RESET_PC);
    end
    expect_first(RESET_PC, "wrap_restart");
  endtask

  task automatic test_random();
    logic ov; logic [31:0] opc, oins, ia;
    logic rdy, rv, rs, flushed;
    logic [31:0] rpc, exp_pc;
    int xfers;
    cache_delay = 0;
    do_reset();
    exp_pc = RESET_PC; flushed = 1'b0; xfers = 0;
    for (int c = 0; c < 1200; c++) begin
      if (c % 200 == 0) cache_delay = $urandom_range(0, 3);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 24) == 0);
      rs  = ($urandom_range(0, 99) == 0);
      rpc = $urandom;
      step(rdy, rv, rpc, rs, ov, opc, oins, ia);
      if (flushed) begin
        vectors++; if (ov !== 1'b0) begin errors++; $display("FAIL rand_flush cyc=%0d valid=%b want=0", c, ov); end
      end
      if (ov && rdy && !rs) begin
        vectors++; if (opc !== exp_pc || oins !== rom(exp_pc)) begin
          errors++; $display("FAIL rand_order cyc=%0d pc=%h instr=%h want pc=%h instr=%h", c, opc, oins, exp_pc, rom(exp_pc));
        end
        exp_pc += 4; xfers++;
      end
      if (rs) exp_pc = RESET_PC;
      else if (rv) exp_pc = {rpc[31:2], 2'b00};
      flushed = rs || rv;
    end
    vectors++; if (xfers < 100) begin errors++; $display("FAIL rand_progress xfers=%0d want>=100", xfers); end
  endtask

  initial begin
    test_reset();
    test_stream(0, 2, 29);
    test_stream(3, 5, 12);
    test_full();
    test_redirect();
    test_redirect_pop();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded at reset.
REQ-002 Parameter DEPTH, default 4: instruction queue entries; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 icache_address  output  32  fetch address to instruction cache.
REQ-006 icache_instruction  input  32  cache read data, registered in cache one cycle after address.
REQ-007 icache_valid  input  1  cache data-ready indication.
REQ-008 redirect_valid  input  1  branch/exception redirect request.
REQ-009 redirect_pc  input  32  redirect target.
REQ-010 out_valid  output  1  queue head valid to decode.
REQ-011 out_ready  input  1  decode accepts head.
REQ-012 out_instr  output  32  head instruction word.
REQ-013 out_pc  output  32  head instruction address.

Function
REQ-014 The unit SHALL hold a registered pc and drive icache_address = pc directly from that register, with no combinational input path.
REQ-015 pc[1:0] SHALL always be 2'b00; redirect_pc[1:0] ignored.
REQ-016 FSM states SHALL be SETTLE and WAIT.
REQ-017 SETTLE SHALL last exactly one cycle and move to WAIT; icache inputs ignored (cache data and valid stale while the cache registers the new address).
REQ-018 In WAIT, capture SHALL occur when icache_valid=1 and queue count < DEPTH: push {pc, icache_instruction}, pc <= pc+4, next state SETTLE.
REQ-019 In WAIT with icache_valid=0 or queue full, pc SHALL hold and state SHALL stay WAIT.
REQ-020 Fullness SHALL use the current-cycle count; a same-cycle pop does not enable a capture.
REQ-021 Steady-state throughput SHALL be one instruction per 2 cycles with icache_valid held 1; an N-cycle cache delay adds N cycles per fetch.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-023 Queue SHALL be a FIFO with wrapping read and write pointers and a count from 0 to DEPTH.
REQ-024 out_valid SHALL be (count != 0); out_instr and out_pc SHALL present the head entry.
REQ-025 A transfer SHALL occur when out_valid && out_ready; the head is then removed at the edge.
REQ-026 Simultaneous push and pop SHALL leave count unchanged.
REQ-027 out_instr and out_pc SHALL be don't-care while out_valid=0.
REQ-028 A redirect SHALL have highest priority: pc <= {redirect_pc[31:2],2'b00}, state <= SETTLE, queue emptied (count=0, pointers reset), and no capture that cycle.
REQ-029 A handshake in the redirect cycle SHALL count as a completed transfer of the old head, and the queue SHALL still be emptied.
REQ-030 Back-to-back redirects SHALL each take effect; the last one wins.
REQ-031 Instructions SHALL be queued strictly in fetch order, with no duplicates and no drops except on redirect.

Reset
REQ-032 While rst=1: pc=RESET_PC, state=SETTLE, count=0, pointers=0, out_valid=0, icache_address=RESET_PC.
REQ-033 rst SHALL take priority over redirect_valid and all handshakes.
REQ-034 Reset mid-fetch or with a non-empty queue SHALL discard everything and restart fetch at RESET_PC.
REQ-035 The first capture after reset SHALL occur no earlier than the second rising edge after rst deasserts.

Verification
REQ-036 Cache delay=0, out_ready=1, memory word i = i: out_pc sequence 0,4,8,... and out_instr 0,1,2,..., one every 2 cycles.
REQ-037 Cache delay=3: each fetch takes 5 cycles and no stale word is captured; instr at pc=0x8 equals rom[2].
REQ-038 out_ready=0, DEPTH=4: exactly 4 entries captured, then pc holds at 0x10 in WAIT; on out_ready=1, capture resumes with pc=0x10 and no gaps.
REQ-039 Redirect to 0x103 with 3 entries queued: out_valid=0 next cycle, pc=0x100, first new output out_pc=0x100.
REQ-040 Redirect in the same cycle as icache_valid=1 and a pop: no push, old head counted as transferred, fetch resumes at the target.
REQ-041 Redirect to 0xFFFF_FFFC: outputs 0xFFFF_FFFC then 0x0000_0000; assert rst mid-WAIT -> out_valid=0, icache_address=RESET_PC next cycle.
